// File: rtl/msx2_mapper_ram_access.sv
// MSX2 mapper RAM sequencer: segment/offset to linear RAM address, req/ack handshake, CPU wait.
// Optional acknowledge watchdog enabled by defining MSX2_RAM_ACCESS_TIMEOUT_EN.
module msx2_mapper_ram_access #(
    parameter int unsigned RAM_AW  = 22,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic [7:0]        segment,
    input  logic [7:0]        size,
    input  logic [RAM_AW-1:0] ram_base,
    output logic              cpu_wait,
    output logic [7:0]        q,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic              ram_ack,
    input  logic [7:0]        ram_dout,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic              to_fire;
    logic              is_rd;
    logic [7:0]        rdata;
    logic [7:0]        seg_mask;
    logic [RAM_AW-1:0] addr_r;
    logic [7:0]        din_r;

    // Page select bits are consumed upstream by the mapper register file.
    logic unused_bits;
    assign unused_bits = ^cpu_addr[15:14];

    assign accept   = !reset && (state == IDLE) && mem_req && (mem_rd || mem_wr);
    assign seg_mask = segment & (size - 8'd1);

`ifdef MSX2_RAM_ACCESS_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] to_cnt;
    logic          to_err;

    assign to_fire     = (state == WAIT_ACK) && !ram_ack && (to_cnt == CW'(TIMEOUT - 1));
    assign timeout_err = to_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            to_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                to_cnt <= '0;
            else if (state == WAIT_ACK)
                to_cnt <= to_cnt + 1'b1;
            if (to_fire)
                to_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign to_fire        = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cpu_wait  = 1'b0;
        ram_rd    = 1'b0;
        ram_wr    = 1'b0;
        q         = 8'hFF;
        case (state)
            IDLE: begin
                cpu_wait = accept;
                if (accept)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                cpu_wait  = 1'b1;
                ram_rd    = is_rd;
                ram_wr    = !is_rd;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                cpu_wait = 1'b1;
                if (ram_ack || to_fire)
                    state_nxt = DONE;
            end
            DONE: begin
                if (is_rd)
                    q = rdata;
                if (!mem_rd && !mem_wr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_rd  <= 1'b0;
            rdata  <= 8'hFF;
            addr_r <= '0;
            din_r  <= '0;
        end else begin
            if (accept) begin
                is_rd  <= mem_rd;
                addr_r <= ram_base + RAM_AW'({seg_mask, cpu_addr[13:0]});
                din_r  <= cpu_data;
            end
            if (state == WAIT_ACK) begin
                if (ram_ack && is_rd)
                    rdata <= ram_dout;
                else if (to_fire)
                    rdata <= 8'hFF;
            end
        end
    end

    assign ram_addr = addr_r;
    assign ram_din  = din_r;

endmodule
